// File: rtl/floating_point_control.sv
// Sequencer for the floating-point add/sub datapath.
// Moore control: outputs depend only on state and latched status.
module floating_point_control #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int ADD_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op_sub,
  input  logic                  sign1,
  input  logic                  sign2,
  input  logic [EXP_WIDTH-1:0]  expDiff,
  input  logic                  carryOut,
  input  logic [4:0]            leadingZeros,
  input  logic                  mantissaZero,
  input  logic                  expOverflow,
  input  logic                  expUnderflow,
  output logic                  controlToMux01,
  output logic                  controlToMux02,
  output logic                  controlToMux03,
  output logic                  controlToMux04,
  output logic                  controlToMux05,
  output logic                  controlToMux06,
  output logic [EXP_WIDTH-1:0]  controlShiftRight,
  output logic [3:0]            controlToIncreaseOrDecrease,
  output logic                  IncreaseOrDecreaseEnable,
  output logic [EXP_WIDTH-1:0]  howManyToIncreaseOrDecrease,
  output logic                  rightOrLeft,
  output logic [MANT_WIDTH-1:0] howMany,
  output logic                  isSum,
  output logic                  sum_sub,
  output logic                  bigALUReset,
  output logic                  muxDataRegValor2,
  output logic [3:0]            smallALUOperation,
  output logic                  muxAControlSmall,
  output logic                  muxBControlSmall,
  output logic                  loadRegSmall,
  output logic                  busy,
  output logic                  finalizeOperation,
  output logic                  overflow,
  output logic                  underflow
);

  typedef enum logic [2:0] {
    IDLE, EXP_SUB, EXP_CAP, ALIGN, ADD, NORM, DONE
  } state_t;

  localparam logic [EXP_WIDTH:0] SAT =
    (EXP_WIDTH+1)'(MANT_WIDTH + 2);
  localparam logic [3:0] ADD_LAST = 4'(ADD_CYCLES - 1);

  state_t state_q, state_d;
  logic                 eff_sub_q;
  logic                 swap_q;
  logic [EXP_WIDTH-1:0] mag_q;
  logic [3:0]           cnt_q;
  logic                 carry_q;
  logic [4:0]           lz_q;
  logic                 zero_q;
  logic                 ovf_q;
  logic                 unf_q;

  logic [EXP_WIDTH:0]   abs_d;
  logic [EXP_WIDTH-1:0] mag_d;

  // Widened by one bit so the most negative difference still has a magnitude.
  always_comb begin
    if (expDiff[EXP_WIDTH-1])
      abs_d = {1'b0, ~expDiff} + 1'b1;
    else
      abs_d = {1'b0, expDiff};
    mag_d = (abs_d > SAT) ? SAT[EXP_WIDTH-1:0]
                          : abs_d[EXP_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      eff_sub_q <= 1'b0;
      swap_q    <= 1'b0;
      mag_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      lz_q      <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start)
            eff_sub_q <= sign1 ^ sign2 ^ op_sub;
        end
        EXP_CAP: begin
          swap_q <= expDiff[EXP_WIDTH-1];
          mag_q  <= mag_d;
        end
        ADD: begin
          if (cnt_q == ADD_LAST) begin
            cnt_q   <= '0;
            carry_q <= carryOut;
            lz_q    <= leadingZeros;
            zero_q  <= mantissaZero;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        NORM: begin
          ovf_q <= expOverflow;
          unf_q <= expUnderflow;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = EXP_SUB;
      EXP_SUB: state_d = EXP_CAP;
      EXP_CAP: state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     if (cnt_q == ADD_LAST) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    controlToMux01              = 1'b0;
    controlToMux02              = 1'b0;
    controlToMux03              = 1'b0;
    controlToMux04              = 1'b0;
    controlToMux05              = 1'b0;
    controlToMux06              = 1'b0;
    controlShiftRight           = '0;
    controlToIncreaseOrDecrease = 4'b0000;
    IncreaseOrDecreaseEnable    = 1'b0;
    howManyToIncreaseOrDecrease = '0;
    rightOrLeft                 = 1'b0;
    howMany                     = '0;
    isSum                       = 1'b0;
    sum_sub                     = 1'b0;
    bigALUReset                 = 1'b0;
    muxDataRegValor2            = 1'b0;
    smallALUOperation           = 4'b0000;
    muxAControlSmall            = 1'b0;
    muxBControlSmall            = 1'b0;
    loadRegSmall                = 1'b0;
    busy                        = (state_q != IDLE);
    finalizeOperation           = 1'b0;
    overflow                    = 1'b0;
    underflow                   = 1'b0;
    unique case (state_q)
      EXP_SUB: begin
        smallALUOperation = 4'b0011;
        loadRegSmall      = 1'b1;
      end
      ALIGN: begin
        controlToMux01    = swap_q;
        controlToMux04    = swap_q;
        controlShiftRight = mag_q;
      end
      ADD: begin
        controlToMux01 = swap_q;
        controlToMux04 = swap_q;
        isSum          = 1'b1;
        sum_sub        = eff_sub_q;
      end
      NORM: begin
        if (zero_q) begin
          controlToMux06 = 1'b1;
        end else if (carry_q) begin
          rightOrLeft                 = 1'b1;
          howMany                     = MANT_WIDTH'(1);
          IncreaseOrDecreaseEnable    = 1'b1;
          howManyToIncreaseOrDecrease = EXP_WIDTH'(1);
          controlToMux03              = 1'b1;
        end else if (lz_q != 5'd0) begin
          howMany                     = MANT_WIDTH'(lz_q);
          IncreaseOrDecreaseEnable    = 1'b1;
          controlToIncreaseOrDecrease = 4'b0001;
          howManyToIncreaseOrDecrease = EXP_WIDTH'(lz_q);
          controlToMux03              = 1'b1;
        end
      end
      DONE: begin
        finalizeOperation = 1'b1;
        overflow          = ovf_q;
        underflow         = unf_q;
        controlToMux05    = ovf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_floating_point_control.sv
// Scoreboard bench for floating_point_control.
// Two instances: default ADD length and a 3-cycle ADD.
module tb_floating_point_control;

  logic clk, reset, start, op_sub, sign1, sign2;
  logic [7:0] expDiff;
  logic carryOut, mantissaZero, expOverflow, expUnderflow;
  logic [4:0] leadingZeros;

  logic a_m1, a_m2, a_m3, a_m4, a_m5, a_m6;
  logic [7:0] a_csr, a_hmiod;
  logic [3:0] a_ciod, a_salu;
  logic a_iode, a_rol, a_is, a_ss, a_bar, a_mdr;
  logic [22:0] a_hm;
  logic a_ma, a_mb, a_lr, a_busy, a_fin, a_ovf, a_unf;

  logic b_m1, b_m2, b_m3, b_m4, b_m5, b_m6;
  logic [7:0] b_csr, b_hmiod;
  logic [3:0] b_ciod, b_salu;
  logic b_iode, b_rol, b_is, b_ss, b_bar, b_mdr;
  logic [22:0] b_hm;
  logic b_ma, b_mb, b_lr, b_busy, b_fin, b_ovf, b_unf;

  logic [65:0] va, vb;
  assign va = {a_m1, a_m2, a_m3, a_m4, a_m5, a_m6,
               a_csr, a_ciod, a_iode, a_hmiod, a_rol,
               a_hm, a_is, a_ss, a_bar, a_mdr, a_salu,
               a_ma, a_mb, a_lr, a_busy, a_fin,
               a_ovf, a_unf};
  assign vb = {b_m1, b_m2, b_m3, b_m4, b_m5, b_m6,
               b_csr, b_ciod, b_iode, b_hmiod, b_rol,
               b_hm, b_is, b_ss, b_bar, b_mdr, b_salu,
               b_ma, b_mb, b_lr, b_busy, b_fin,
               b_ovf, b_unf};

  floating_point_control u_a (
    .clk(clk), .reset(reset), .start(start),
    .op_sub(op_sub), .sign1(sign1), .sign2(sign2),
    .expDiff(expDiff), .carryOut(carryOut),
    .leadingZeros(leadingZeros),
    .mantissaZero(mantissaZero),
    .expOverflow(expOverflow),
    .expUnderflow(expUnderflow),
    .controlToMux01(a_m1), .controlToMux02(a_m2),
    .controlToMux03(a_m3), .controlToMux04(a_m4),
    .controlToMux05(a_m5), .controlToMux06(a_m6),
    .controlShiftRight(a_csr),
    .controlToIncreaseOrDecrease(a_ciod),
    .IncreaseOrDecreaseEnable(a_iode),
    .howManyToIncreaseOrDecrease(a_hmiod),
    .rightOrLeft(a_rol), .howMany(a_hm),
    .isSum(a_is), .sum_sub(a_ss),
    .bigALUReset(a_bar), .muxDataRegValor2(a_mdr),
    .smallALUOperation(a_salu),
    .muxAControlSmall(a_ma), .muxBControlSmall(a_mb),
    .loadRegSmall(a_lr), .busy(a_busy),
    .finalizeOperation(a_fin),
    .overflow(a_ovf), .underflow(a_unf)
  );

  floating_point_control #(.ADD_CYCLES(3)) u_b (
    .clk(clk), .reset(reset), .start(start),
    .op_sub(op_sub), .sign1(sign1), .sign2(sign2),
    .expDiff(expDiff), .carryOut(carryOut),
    .leadingZeros(leadingZeros),
    .mantissaZero(mantissaZero),
    .expOverflow(expOverflow),
    .expUnderflow(expUnderflow),
    .controlToMux01(b_m1), .controlToMux02(b_m2),
    .controlToMux03(b_m3), .controlToMux04(b_m4),
    .controlToMux05(b_m5), .controlToMux06(b_m6),
    .controlShiftRight(b_csr),
    .controlToIncreaseOrDecrease(b_ciod),
    .IncreaseOrDecreaseEnable(b_iode),
    .howManyToIncreaseOrDecrease(b_hmiod),
    .rightOrLeft(b_rol), .howMany(b_hm),
    .isSum(b_is), .sum_sub(b_ss),
    .bigALUReset(b_bar), .muxDataRegValor2(b_mdr),
    .smallALUOperation(b_salu),
    .muxAControlSmall(b_ma), .muxBControlSmall(b_mb),
    .loadRegSmall(b_lr), .busy(b_busy),
    .finalizeOperation(b_fin),
    .overflow(b_ovf), .underflow(b_unf)
  );

  typedef struct {
    logic       s1, s2, sub;
    logic [7:0] ed;
    logic       c;
    logic [4:0] lz;
    logic       z, ov, un;
    int         t0;
  } item_t;

  item_t qa[$], qb[$];
  int n_run = 0, n_fail = 0, ncyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [65:0] got,
                     input logic [65:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference outputs for cycle k after start acceptance.
  function automatic logic [65:0] exp_vec(
    input item_t it, input int k, input int ac);
    logic m1, m3, m4, m5, m6, iode, rol;
    logic is, ss, lr, bsy, fin, ov, un;
    logic [7:0] csr, hmiod;
    logic [3:0] ciod, salu;
    logic [22:0] hm;
    logic sw;
    int d, mag;
    {m1, m3, m4, m5, m6, iode, rol} = '0;
    {is, ss, lr, fin, ov, un} = '0;
    csr = '0; hmiod = '0; ciod = '0;
    salu = '0; hm = '0;
    bsy = (k >= 1 && k <= 5 + ac);
    sw = it.ed[7];
    d = int'($signed(it.ed));
    mag = (d < 0) ? -d : d;
    if (mag > 25) mag = 25;
    if (k == 1) begin
      salu = 4'b0011; lr = 1'b1;
    end else if (k == 3) begin
      m1 = sw; m4 = sw; csr = 8'(mag);
    end else if (k >= 4 && k <= 3 + ac) begin
      m1 = sw; m4 = sw; is = 1'b1;
      ss = it.s1 ^ it.s2 ^ it.sub;
    end else if (k == 4 + ac) begin
      if (it.z) m6 = 1'b1;
      else if (it.c) begin
        rol = 1'b1; hm = 23'd1; iode = 1'b1;
        hmiod = 8'd1; m3 = 1'b1;
      end else if (it.lz != 0) begin
        hm = 23'(it.lz); iode = 1'b1;
        ciod = 4'b0001; hmiod = 8'(it.lz);
        m3 = 1'b1;
      end
    end else if (k == 5 + ac) begin
      fin = 1'b1; ov = it.ov; un = it.un;
      m5 = it.ov;
    end
    return {m1, 1'b0, m3, m4, m5, m6, csr, ciod,
            iode, hmiod, rol, hm, is, ss, 1'b0,
            1'b0, salu, 1'b0, 1'b0, lr, bsy, fin,
            ov, un};
  endfunction

  always @(negedge clk) begin
    int k;
    logic [65:0] e;
    ncyc++;
    if (!reset) begin
      chk("rst_a", va, '0);
      chk("rst_b", vb, '0);
      qa.delete();
      qb.delete();
    end else begin
      e = '0;
      k = 0;
      if (qa.size() > 0) k = ncyc - qa[0].t0;
      if (qa.size() > 0 && k > 0)
        e = exp_vec(qa[0], k, 1);
      chk($sformatf("a_k%0d", k), va, e);
      if (qa.size() > 0 && k == 6)
        void'(qa.pop_front());
      e = '0;
      k = 0;
      if (qb.size() > 0) k = ncyc - qb[0].t0;
      if (qb.size() > 0 && k > 0)
        e = exp_vec(qb[0], k, 3);
      chk($sformatf("b_k%0d", k), vb, e);
      if (qb.size() > 0 && k == 8)
        void'(qb.pop_front());
    end
  end

  task automatic drive(input item_t it);
    sign1 = it.s1; sign2 = it.s2; op_sub = it.sub;
    expDiff = it.ed; carryOut = it.c;
    leadingZeros = it.lz; mantissaZero = it.z;
    expOverflow = it.ov; expUnderflow = it.un;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", 66'(qa.size() + qb.size()), '0);
    @(posedge clk);
  endtask

  task automatic op(input item_t it, input bit pulse);
    @(posedge clk); #1;
    drive(it);
    start = 1'b1;
    it.t0 = ncyc + 1;
    qa.push_back(it);
    qb.push_back(it);
    @(posedge clk); #1 start = 1'b0;
    if (pulse) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    drain();
  endtask

  function automatic item_t mk(
    input logic s1, s2, sub, input logic [7:0] ed,
    input logic c, input logic [4:0] lz,
    input logic z, ov, un);
    item_t it;
    it.s1 = s1; it.s2 = s2; it.sub = sub;
    it.ed = ed; it.c = c; it.lz = lz;
    it.z = z; it.ov = ov; it.un = un; it.t0 = 0;
    return it;
  endfunction

  initial begin
    item_t it, it2;
    reset = 1'b0; start = 1'b0;
    drive(mk(0, 0, 0, 8'h00, 0, 5'd0, 0, 0, 0));
    #3;
    chk("init_a", va, '0);
    chk("init_b", vb, '0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    op(mk(0, 0, 0, 8'hFF, 0, 5'd0, 0, 0, 0), 0);
    op(mk(0, 0, 0, 8'h02, 1, 5'd0, 0, 0, 0), 0);
    op(mk(0, 0, 1, 8'h00, 0, 5'd3, 0, 0, 0), 1);
    op(mk(0, 0, 1, 8'h00, 1, 5'd4, 1, 0, 0), 0);
    op(mk(0, 0, 0, 8'h80, 0, 5'd0, 0, 0, 0), 0);
    op(mk(0, 0, 0, 8'h1A, 0, 5'd0, 0, 0, 0), 0);
    op(mk(1, 0, 0, 8'h07, 0, 5'd31, 0, 1, 0), 0);
    op(mk(1, 1, 1, 8'hE0, 1, 5'd2, 0, 0, 1), 0);

    // Held start: A restarts 7 cycles later, B only once.
    it = mk(0, 1, 0, 8'h03, 0, 5'd5, 0, 0, 0);
    @(posedge clk); #1;
    drive(it);
    start = 1'b1;
    it.t0 = ncyc + 1;
    qa.push_back(it);
    qb.push_back(it);
    it2 = it;
    it2.t0 = it.t0 + 7;
    qa.push_back(it2);
    repeat (8) @(posedge clk);
    #1 start = 1'b0;
    drain();

    // Reset asserted while both instances are in ADD.
    it = mk(0, 0, 0, 8'h01, 0, 5'd0, 0, 1, 1);
    @(posedge clk); #1;
    drive(it);
    start = 1'b1;
    it.t0 = ncyc + 1;
    qa.push_back(it);
    qb.push_back(it);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_a", va, '0);
    chk("async_b", vb, '0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (12) @(posedge clk);

    op(mk(0, 0, 0, 8'hFE, 0, 5'd1, 0, 0, 0), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
